// File: rtl/pc_sequencer_if.sv
// Control bus between the multicycle sequencer and the datapath/memory side.
// The sequencer takes the master modport; the datapath and memory take the slave modport.
interface pc_sequencer_if;
    logic [3:0] Opcode;
    logic       MemReady;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       Branch;
    logic       bneOrbeq;
    logic       IRWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       AccWrite;
    logic [1:0] AccSrc;
    logic [1:0] ALUOp;
    logic       Halted;
    logic       Fault;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCSrc, Branch, bneOrbeq, IRWrite, MemRead, MemWrite,
               AccWrite, AccSrc, ALUOp, Halted, Fault
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCSrc, Branch, bneOrbeq, IRWrite, MemRead, MemWrite,
               AccWrite, AccSrc, ALUOp, Halted, Fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle control FSM for the 16-bit accumulator processor.
// Sequences fetch, decode, memory access, write-back and PC updates, and
// bounds every memory handshake with a wait counter.
//
// state  | meaning
// RESET  | all outputs low, Fault cleared
// FETCH  | read instruction; PC+2 load on MemReady
// DECODE | latch opcode and dispatch
// MEMRD  | operand read; LOAD writes the accumulator on MemReady
// ALU    | accumulator <= ALU result
// STORE  | memory write until MemReady
// LI     | accumulator <= immediate
// BRANCH | conditional PC load (beq/bne)
// JUMP   | unconditional PC load from jump target
// HALT   | stopped; left only by reset
module pc_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            CLK,
    input  logic            reset,
    pc_sequencer_if.master  bus
);
    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMRD, S_ALU,
        S_STORE, S_LI, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    // 9 bits so a limit of 255 compares cleanly against count + 1
    localparam logic [8:0] LIMIT = 9'(MEM_TIMEOUT);

    state_t     state, state_nx;
    logic [3:0] op_q;
    logic [7:0] wait_cnt;
    logic       fault_q;
    logic       set_fault;
    logic       mem_state;
    logic       timeout;

    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_STORE);
    // Fires in the wait cycle whose increment would bring the count to the limit;
    // a MemReady in that same cycle suppresses it, so the handshake wins.
    assign timeout   = (LIMIT != 9'd0) && mem_state && !bus.MemReady &&
                       (({1'b0, wait_cnt} + 9'd1) == LIMIT);
    assign bus.Fault = fault_q;

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= S_RESET;
        else        state <= state_nx;
    end

    // Opcode latch, loaded only while decoding
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)                  op_q <= 4'h0;
        else if (state == S_DECODE)  op_q <= bus.Opcode;
    end

    // Memory-wait counter: restarts on every state change, counts stalled cycles
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)                                         wait_cnt <= 8'd0;
        else if (state_nx != state)                         wait_cnt <= 8'd0;
        else if (mem_state && !bus.MemReady && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
    end

    // Sticky fault flag, cleared only in RESET
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)                 fault_q <= 1'b0;
        else if (state == S_RESET)  fault_q <= 1'b0;
        else if (set_fault)         fault_q <= 1'b1;
    end

    // Next-state and output decode
    always_comb begin
        state_nx     = state;
        set_fault    = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.PCSrc    = 2'b00;
        bus.Branch   = 1'b0;
        bus.bneOrbeq = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.AccWrite = 1'b0;
        bus.AccSrc   = 2'b00;
        bus.ALUOp    = 2'b00;
        bus.Halted   = 1'b0;
        case (state)
            S_RESET: state_nx = S_FETCH;
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = 1'b1;
                if (timeout) begin
                    set_fault = 1'b1;
                    state_nx  = S_HALT;
                end else if (bus.MemReady) begin
                    bus.PCWrite = 1'b1;
                    state_nx    = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.Opcode)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4: state_nx = S_MEMRD;
                    4'h5:                         state_nx = S_STORE;
                    4'h6:                         state_nx = S_LI;
                    4'h7, 4'h8:                   state_nx = S_BRANCH;
                    4'h9:                         state_nx = S_JUMP;
                    4'hF:                         state_nx = S_HALT;
                    default: begin
                        set_fault = 1'b1;
                        state_nx  = S_FETCH;
                    end
                endcase
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                if (timeout) begin
                    set_fault = 1'b1;
                    state_nx  = S_HALT;
                end else if (bus.MemReady) begin
                    if (op_q == 4'h4) begin
                        bus.AccWrite = 1'b1;
                        bus.AccSrc   = 2'b01;
                        state_nx     = S_FETCH;
                    end else begin
                        state_nx = S_ALU;
                    end
                end
            end
            S_ALU: begin
                bus.AccWrite = 1'b1;
                bus.ALUOp    = op_q[1:0];
                state_nx     = S_FETCH;
            end
            S_STORE: begin
                bus.MemWrite = 1'b1;
                if (timeout) begin
                    set_fault = 1'b1;
                    state_nx  = S_HALT;
                end else if (bus.MemReady) begin
                    state_nx = S_FETCH;
                end
            end
            S_LI: begin
                bus.AccWrite = 1'b1;
                bus.AccSrc   = 2'b10;
                state_nx     = S_FETCH;
            end
            S_BRANCH: begin
                bus.Branch   = 1'b1;
                bus.PCSrc    = 2'b01;
                bus.bneOrbeq = (op_q == 4'h7);
                state_nx     = S_FETCH;
            end
            S_JUMP: begin
                bus.PCWrite = 1'b1;
                bus.PCSrc   = 2'b10;
                state_nx    = S_FETCH;
            end
            S_HALT:  bus.Halted = 1'b1;
            default: state_nx = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-cycle stimulus plans with
// expected output vectors pushed to a scoreboard and compared against
// the outputs captured in the same cycle.
module tb_pc_sequencer;
    typedef struct packed {
        logic       pcw;
        logic [1:0] pcsrc;
        logic       br;
        logic       boe;
        logic       irw;
        logic       mr;
        logic       mw;
        logic       aw;
        logic [1:0] accsrc;
        logic [1:0] aluop;
        logic       halted;
        logic       fault;
    } vec_t;

    typedef struct {
        logic [3:0] op;
        logic       rdy;
        vec_t       exp;
    } step_t;

    logic CLK;
    logic reset;
    pc_sequencer_if bus();

    pc_sequencer #(.MEM_TIMEOUT(4)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    vec_t  got;
    step_t plan[$];
    vec_t  sb[$];
    vec_t  act[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    assign got = {bus.PCWrite, bus.PCSrc, bus.Branch, bus.bneOrbeq, bus.IRWrite,
                  bus.MemRead, bus.MemWrite, bus.AccWrite, bus.AccSrc, bus.ALUOp,
                  bus.Halted, bus.Fault};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Expected outputs per state, written from the state table
    function automatic vec_t s_zero(input logic f);
        vec_t v = '0;
        v.fault = f;
        return v;
    endfunction
    function automatic vec_t s_fetch(input logic rdy, input logic f);
        vec_t v = s_zero(f);
        v.mr = 1'b1; v.irw = 1'b1; v.pcw = rdy;
        return v;
    endfunction
    function automatic vec_t s_memrd(input logic load, input logic rdy, input logic f);
        vec_t v = s_zero(f);
        v.mr = 1'b1;
        if (load && rdy) begin v.aw = 1'b1; v.accsrc = 2'b01; end
        return v;
    endfunction
    function automatic vec_t s_alu(input logic [1:0] op, input logic f);
        vec_t v = s_zero(f);
        v.aw = 1'b1; v.aluop = op;
        return v;
    endfunction
    function automatic vec_t s_store(input logic f);
        vec_t v = s_zero(f);
        v.mw = 1'b1;
        return v;
    endfunction
    function automatic vec_t s_li(input logic f);
        vec_t v = s_zero(f);
        v.aw = 1'b1; v.accsrc = 2'b10;
        return v;
    endfunction
    function automatic vec_t s_branch(input logic beq, input logic f);
        vec_t v = s_zero(f);
        v.br = 1'b1; v.pcsrc = 2'b01; v.boe = beq;
        return v;
    endfunction
    function automatic vec_t s_jump(input logic f);
        vec_t v = s_zero(f);
        v.pcw = 1'b1; v.pcsrc = 2'b10;
        return v;
    endfunction
    function automatic vec_t s_halt(input logic f);
        vec_t v = s_zero(f);
        v.halted = 1'b1;
        return v;
    endfunction

    task automatic add(input logic [3:0] op, input logic rdy, input vec_t e);
        step_t s;
        s.op = op; s.rdy = rdy; s.exp = e;
        plan.push_back(s);
    endtask

    // Drive each planned cycle, push its expectation, capture the DUT outputs
    task automatic run_plan();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(negedge CLK);
            bus.Opcode   = s.op;
            bus.MemReady = s.rdy;
            sb.push_back(s.exp);
            #1;
            act.push_back(got);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        vec_t e, a;
        reset = 1'b0;
        bus.Opcode = 4'h0;
        bus.MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (i == 2) reset = 1'b1;
            sb.push_back(s_zero(1'b0));
            #1;
            act.push_back(got);
        end
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); a = act.pop_front(); n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h required %h", i, a, e);
            end
        end
    endtask

    task automatic test_alu_ops();
        vec_t e, a;
        add(4'h0, 1, s_fetch(1, 0)); add(4'h0, 1, s_zero(0));
        add(4'h0, 1, s_memrd(0, 1, 0)); add(4'h0, 1, s_alu(2'b00, 0));
        add(4'h3, 1, s_fetch(1, 0)); add(4'h3, 1, s_zero(0));
        add(4'h3, 1, s_memrd(0, 1, 0)); add(4'h3, 1, s_alu(2'b11, 0));
        add(4'h4, 1, s_fetch(1, 0)); add(4'h4, 1, s_zero(0));
        add(4'h4, 1, s_memrd(1, 1, 0));
        add(4'h6, 1, s_fetch(1, 0)); add(4'h6, 1, s_zero(0)); add(4'h6, 1, s_li(0));
        run_plan();
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); a = act.pop_front(); n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL alu_ops cycle %0d: got %h required %h", i, a, e);
            end
        end
    endtask

    task automatic test_branch_jump();
        vec_t e, a;
        add(4'h7, 1, s_fetch(1, 0)); add(4'h7, 1, s_zero(0)); add(4'h7, 1, s_branch(1, 0));
        add(4'h8, 1, s_fetch(1, 0)); add(4'h8, 1, s_zero(0)); add(4'h8, 1, s_branch(0, 0));
        add(4'h9, 1, s_fetch(1, 0)); add(4'h9, 1, s_zero(0)); add(4'h9, 1, s_jump(0));
        run_plan();
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); a = act.pop_front(); n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL branch_jump cycle %0d: got %h required %h", i, a, e);
            end
        end
    endtask

    // Three stalls with a limit of 4: MemReady lands in the last legal cycle
    task automatic test_store_wait();
        vec_t e, a;
        add(4'h5, 0, s_fetch(0, 0)); add(4'h5, 1, s_fetch(1, 0)); add(4'h5, 1, s_zero(0));
        add(4'h5, 0, s_store(0)); add(4'h5, 0, s_store(0)); add(4'h5, 0, s_store(0));
        add(4'h5, 1, s_store(0));
        add(4'h0, 0, s_fetch(0, 0));
        run_plan();
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); a = act.pop_front(); n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL store_wait cycle %0d: got %h required %h", i, a, e);
            end
        end
    endtask

    task automatic test_illegal_halt();
        vec_t e, a;
        add(4'hB, 1, s_fetch(1, 0)); add(4'hB, 1, s_zero(0));
        add(4'hF, 1, s_fetch(1, 1)); add(4'hF, 1, s_zero(1));
        add(4'hF, 1, s_halt(1)); add(4'h0, 0, s_halt(1)); add(4'h5, 1, s_halt(1));
        run_plan();
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); a = act.pop_front(); n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL illegal_halt cycle %0d: got %h required %h", i, a, e);
            end
        end
    endtask

    task automatic test_timeout();
        vec_t e, a;
        do_reset();
        add(4'h0, 1, s_fetch(1, 0)); add(4'h0, 1, s_zero(0));
        for (int k = 0; k < 4; k++) add(4'h0, 0, s_memrd(0, 0, 0));
        add(4'h0, 1, s_halt(1)); add(4'h0, 0, s_halt(1)); add(4'h0, 1, s_halt(1));
        run_plan();
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); a = act.pop_front(); n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL timeout cycle %0d: got %h required %h", i, a, e);
            end
        end
        @(negedge CLK);
        reset = 1'b0;
        #1;
        n_checks++;
        if (got !== s_zero(0)) begin
            n_fail++;
            $display("FAIL timeout_clear: got %h required %h", got, s_zero(0));
        end
    endtask

    task automatic test_mid_store_reset();
        vec_t e, a;
        do_reset();
        add(4'h5, 1, s_fetch(1, 0)); add(4'h5, 1, s_zero(0)); add(4'h5, 0, s_store(0));
        run_plan();
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); a = act.pop_front(); n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL mid_store cycle %0d: got %h required %h", i, a, e);
            end
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (got !== s_zero(0)) begin
            n_fail++;
            $display("FAIL mid_store_reset: got %h required %h", got, s_zero(0));
        end
        @(negedge CLK);
        reset = 1'b1;
        add(4'h0, 1, s_fetch(1, 0));
        run_plan();
        e = sb.pop_front(); a = act.pop_front(); n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL mid_store_refetch: got %h required %h", a, e);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_branch_jump();
        test_store_wait();
        test_illegal_halt();
        test_timeout();
        test_mid_store_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
